// File: rtl/rng_pkg.sv
//------------------------------------------------------------------------------
// rng_pkg : shared types and helpers for the bounded random-number blocks
// Rev 1.0 : initial release
//------------------------------------------------------------------------------
`default_nettype none

package rng_pkg;

  localparam int RNG_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MASK = 2'd1,
    ST_DRAW = 2'd2,
    ST_OUT  = 2'd3
  } rng_state_e;

  // Smear the highest set bit downwards, giving the smallest 2^k-1 >= w32.
  function automatic logic [RNG_W-1:0] fill_mask(input logic [RNG_W-1:0] w32);
    logic [RNG_W-1:0] m;
    m = w32;
    m = m | (m >> 1);
    m = m | (m >> 2);
    m = m | (m >> 4);
    m = m | (m >> 8);
    m = m | (m >> 16);
    return m;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rng_bounded.sv
//------------------------------------------------------------------------------
// rng_bounded : maps raw xorshift32 words onto [0, N) by mask-and-reject
// Rev 1.0 : initial release
//------------------------------------------------------------------------------
`default_nettype none

module rng_bounded
  import rng_pkg::*;
#(
  parameter int W     = RNG_W,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [W-1:0]     rnd_data,
  output logic             rnd_ready,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [W-1:0]     req_bound,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_data,
  output logic [CNT_W-1:0] reject_count
);

  rng_state_e       r_state;
  logic [W-1:0]     r_bound;
  logic [W-1:0]     r_mask;
  logic [W-1:0]     r_out;
  logic [CNT_W-1:0] r_rej;

  logic [W-1:0]     w_cand;
  logic             w_accept;
  logic             w_rej_sat;

  assign w_cand    = rnd_data & r_mask;
  // A zero bound stands for the full 2^W range, so every draw is accepted.
  assign w_accept  = (r_bound == '0) || (w_cand < r_bound);
  assign w_rej_sat = (r_rej == {CNT_W{1'b1}});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_bound <= '0;
      r_mask  <= '0;
      r_out   <= '0;
      r_rej   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_bound <= req_bound;
            r_state <= ST_MASK;
          end
        end
        ST_MASK: begin
          r_mask  <= fill_mask(r_bound - W'(1));
          r_state <= ST_DRAW;
        end
        ST_DRAW: begin
          if (w_accept) begin
            r_out   <= w_cand;
            r_state <= ST_OUT;
          end else if (!w_rej_sat) begin
            r_rej <= r_rej + CNT_W'(1);
          end
        end
        ST_OUT: begin
          if (out_ready) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // The generator advances on every DRAW edge, so each word is tested once.
  assign rnd_ready    = (r_state == ST_DRAW);
  assign req_ready    = (r_state == ST_IDLE);
  assign out_valid    = (r_state == ST_OUT);
  assign out_data     = r_out;
  assign reject_count = r_rej;

endmodule

`default_nettype wire

// File: tb/tb_rng_bounded.sv
//------------------------------------------------------------------------------
// tb_rng_bounded : scoreboard bench for rng_bounded with a scripted word source
// Rev 1.0 : initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_rng_bounded;

  localparam logic [31:0] c_SEED = 32'hEBD5A728;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] rnd_data;
  logic        rnd_ready;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_bound = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_data;
  logic [15:0] reject_count;

  always #5 clk = ~clk;

  rng_bounded #(.W(32), .CNT_W(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rnd_data     (rnd_data),
    .rnd_ready    (rnd_ready),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_bound    (req_bound),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .reject_count (reject_count)
  );

  int n_cmp = 0;
  int n_bad = 0;

  function automatic logic [31:0] xs_next(input logic [31:0] x);
    logic [31:0] y;
    y = x ^ (x << 13);
    y = y ^ (y >> 17);
    y = y ^ (y << 5);
    return y;
  endfunction

  // Word source: 0 = scripted array, 1 = constant all-ones, 2 = xorshift32
  int          src_mode = 0;
  logic [31:0] script [0:4095];
  int unsigned sidx = 0;
  int unsigned cons = 0;
  logic [31:0] xs = c_SEED;

  always_comb begin
    rnd_data = script[sidx[11:0]];
    if (src_mode == 1) rnd_data = 32'hFFFFFFFF;
    else if (src_mode == 2) rnd_data = xs;
  end

  always @(posedge clk) begin
    if (rnd_ready) begin
      cons <= cons + 1;
      if (src_mode == 0) sidx <= sidx + 1;
      else if (src_mode == 2) xs <= xs_next(xs);
    end
  end

  // Reference model and scoreboard
  typedef struct {
    logic [31:0] data;
    logic [15:0] rej;
    int unsigned ncons;
  } exp_t;

  exp_t        sb[$];
  int unsigned m_idx = 0;
  int unsigned m_cons = 0;
  logic [31:0] m_xs = c_SEED;
  logic [15:0] m_rej = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic summary_and_finish();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  endtask

  task automatic timeout(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL timeout %s: DUT did not respond within its cycle budget", nm);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "timeout");
  endtask

  task automatic model_word(output logic [31:0] w);
    if (src_mode == 2) begin
      w    = m_xs;
      m_xs = xs_next(m_xs);
    end else begin
      w     = script[m_idx[11:0]];
      m_idx = m_idx + 1;
    end
    m_cons = m_cons + 1;
  endtask

  // Smallest 2^k-1 covering N-1, then the first word whose masked value is below N.
  task automatic model_req(input logic [31:0] b);
    longint unsigned msk;
    logic [31:0]     w;
    exp_t            e;
    if (b == 0) msk = 64'hFFFFFFFF;
    else begin
      msk = 0;
      while (msk < longint'(b) - 1) msk = msk * 2 + 1;
    end
    for (int g = 0; g < 100000; g++) begin
      model_word(w);
      if (b == 0 || (w & msk[31:0]) < b) break;
      if (m_rej != 16'hFFFF) m_rej = m_rej + 1;
    end
    e.data  = w & msk[31:0];
    e.rej   = m_rej;
    e.ncons = m_cons;
    sb.push_back(e);
  endtask

  int hist [0:9];
  bit hist_on = 1'b0;

  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_output: got %0h, expected no output", out_data);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("out_data", {32'h0, out_data}, {32'h0, e.data});
        chk("reject_count", {48'h0, reject_count}, {48'h0, e.rej});
        chk("words_consumed", {32'h0, cons}, {32'h0, e.ncons});
        if (hist_on && out_data < 10) hist[out_data] = hist[out_data] + 1;
      end
    end
  end

  task automatic load(input logic [31:0] w[$]);
    foreach (w[i]) script[12'(m_idx + i)] = w[i];
  endtask

  task automatic issue(input logic [31:0] b, input bit predict);
    int g;
    @(negedge clk);
    req_valid = 1'b1;
    req_bound = b;
    g = 0;
    while (!req_ready) begin
      @(negedge clk);
      g++;
      if (g > 500) timeout("req_ready");
    end
    if (predict) model_req(b);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_bound = $urandom;
  endtask

  task automatic drain(input int budget);
    int g;
    g = 0;
    while (sb.size() != 0 || !req_ready) begin
      @(negedge clk);
      g++;
      if (g > budget) timeout("drain");
    end
  endtask

  task automatic latency_check(input string nm, input int exp_n);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 50);
    chk(nm, 64'(n), 64'(exp_n));
  endtask

  bit bp_on = 1'b0;

  initial begin
    int unsigned c0;
    logic [31:0] b;
    logic [31:0] q[$];

    for (int i = 0; i < 4096; i++) script[i] = $urandom;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_rnd_ready", 64'(rnd_ready), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_reject_count", 64'(reject_count), 64'd0);
    rst_n = 1'b1;

    // bound=16: first word accepted, masked value 8
    q = '{32'hEBD5A728};
    load(q);
    c0 = cons;
    issue(32'd16, 1'b1);
    latency_check("lat_bound16", 3);
    chk("d16_data", 64'(out_data), 64'h8);
    chk("d16_rej", 64'(reject_count), 64'd0);
    chk("d16_pulses", 64'(cons - c0), 64'd1);
    drain(50);

    // bound=20: 0x1F rejected, then 0x11 accepted
    q = '{32'h0000001F, 32'h12345611};
    load(q);
    c0 = cons;
    issue(32'd20, 1'b1);
    latency_check("lat_bound20", 4);
    chk("d20_data", 64'(out_data), 64'h11);
    chk("d20_rej", 64'(reject_count), 64'd1);
    chk("d20_pulses", 64'(cons - c0), 64'd2);
    drain(50);

    // bound=0 means full range; bound=1 always yields 0
    q = '{32'hEBD5A728};
    load(q);
    issue(32'd0, 1'b1);
    latency_check("lat_bound0", 3);
    chk("d0_data", 64'(out_data), 64'hEBD5A728);
    drain(50);
    load(q);
    issue(32'd1, 1'b1);
    latency_check("lat_bound1", 3);
    chk("d1_data", 64'(out_data), 64'h0);
    drain(50);

    // Backpressure holds the result and stalls everything else
    out_ready = 1'b0;
    load(q);
    issue(32'd16, 1'b1);
    latency_check("lat_bp", 3);
    repeat (10) begin
      chk("bp_hold_data", 64'(out_data), 64'h8);
      chk("bp_valid", 64'(out_valid), 64'd1);
      chk("bp_rnd_ready", 64'(rnd_ready), 64'd0);
      chk("bp_req_ready", 64'(req_ready), 64'd0);
      @(negedge clk);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_release_req_ready", 64'(req_ready), 64'd1);
    chk("bp_release_valid", 64'(out_valid), 64'd0);
    drain(50);

    // Randomised bounds and words with random consumer backpressure
    for (int i = 0; i < 2000; i++) script[12'(m_idx + i)] = $urandom;
    bp_on = 1'b1;
    fork
      begin
        while (bp_on) begin
          @(posedge clk);
          #1 out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join_none
    for (int i = 0; i < 150; i++) begin
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = 32'd1;
        2: b = 32'd1 << $urandom_range(0, 31);
        3: b = 32'($urandom_range(2, 100));
        4: b = $urandom;
        default: b = (32'd1 << $urandom_range(1, 31)) + 32'd1;
      endcase
      issue(b, 1'b1);
    end
    bp_on = 1'b0;
    @(posedge clk);
    #2 out_ready = 1'b1;
    drain(500);

    // Reset while spinning in DRAW on rejected words
    for (int i = 0; i < 64; i++) script[12'(m_idx + i)] = 32'h00000003;
    issue(32'd3, 1'b0);
    repeat (8) @(negedge clk);
    chk("pre_rst_rnd_ready", 64'(rnd_ready), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_rnd_ready", 64'(rnd_ready), 64'd0);
    chk("midrst_req_ready", 64'(req_ready), 64'd1);
    chk("midrst_reject_count", 64'(reject_count), 64'd0);
    c0 = cons;
    repeat (3) @(negedge clk);
    chk("midrst_no_consume", 64'(cons - c0), 64'd0);
    rst_n = 1'b1;
    m_idx  = sidx;
    m_cons = cons;
    m_rej  = '0;
    for (int i = 0; i < 64; i++) script[12'(m_idx + i)] = $urandom;

    // Integration against a real xorshift32 stream
    src_mode = 2;
    for (int i = 0; i < 10; i++) hist[i] = 0;
    hist_on = 1'b1;
    for (int i = 0; i < 1000; i++) issue(32'd10, 1'b1);
    drain(500);
    hist_on = 1'b0;
    for (int i = 0; i < 10; i++) begin
      n_cmp++;
      if (hist[i] < 70 || hist[i] > 130) begin
        n_bad++;
        $display("FAIL hist_bin%0d: got %0d, expected 70..130", i, hist[i]);
      end
    end

    // Saturation: 70000 rejections of all-ones words against 0x80000001
    src_mode = 1;
    script[m_idx[11:0]] = 32'h0;
    m_idx  = m_idx + 1;
    m_cons = m_cons + 70001;
    m_rej  = 16'hFFFF;
    begin
      exp_t e;
      e.data  = 32'h0;
      e.rej   = 16'hFFFF;
      e.ncons = m_cons;
      sb.push_back(e);
    end
    issue(32'h80000001, 1'b0);
    begin
      int g;
      g = 0;
      while (!rnd_ready) begin
        @(negedge clk);
        g++;
        if (g > 20) timeout("sat_draw");
      end
    end
    repeat (70000) @(posedge clk);
    #1 src_mode = 0;
    drain(100);
    chk("sat_reject_count", 64'(reject_count), 64'hFFFF);

    summary_and_finish();
  end

endmodule

`default_nettype wire
